// File: rtl/dual_port_sram_ctrl_if.sv
// Request/response bundle for the simple-dual-port SRAM bank.
// The transfer engine holds the master side and the bank holds the slave side.
interface dual_port_sram_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              busy;
   logic              drop;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid, busy, drop
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid, busy, drop
   );
endinterface

// File: rtl/dual_port_sram_ctrl.sv
// Simple-dual-port synchronous SRAM bank: one write and one read port on a single clock,
// with configurable read latency, defined read-during-write and a post-reset clear sweep.
module dual_port_sram_ctrl #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 3,
   parameter int                DEPTH    = 8,
   parameter bit                OUT_REG  = 1'b0,
   parameter bit                RDW_MODE = 1'b0,
   parameter bit                INIT_CLR = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
   input logic                 clock,
   input logic                 reset_n,
   dual_port_sram_ctrl_if.slave bus
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // The sweep counter is one bit wider than an address so DEPTH = 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C   = (ADDR_W+1)'(DEPTH - 1);
   localparam state_e          RESET_ST = INIT_CLR ? ST_CLEAR : ST_RUN;

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W:0]   sweep_q, sweep_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_waddr_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic              rd_fire_s;
   logic [DATA_W-1:0] rd_word_s;
   logic              wr_ok_s;
   logic              rd_ok_s;

   assign wr_ok_s = ({1'b0, bus.wr_addr} < DEPTH_C);
   assign rd_ok_s = ({1'b0, bus.rd_addr} < DEPTH_C);

   // Next-state logic: sweep sequencing, request acceptance and refusal reporting.
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      busy_d      = busy_q;
      drop_d      = 1'b0;
      mem_we_s    = 1'b0;
      mem_waddr_s = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
      rd_fire_s   = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            mem_we_s    = 1'b1;
            mem_waddr_s = sweep_q[ADDR_W-1:0];
            mem_wdata_s = INIT_VAL;
            drop_d      = bus.wr_en | bus.rd_en;
            sweep_d     = sweep_q + {{ADDR_W{1'b0}}, 1'b1};
            if (sweep_q == LAST_C) begin
               state_d = ST_RUN;
               busy_d  = 1'b0;
            end else begin
               state_d = ST_CLEAR;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            busy_d    = 1'b0;
            rd_fire_s = bus.rd_en;
            if (bus.wr_en && wr_ok_s) begin
               mem_we_s    = 1'b1;
               mem_waddr_s = bus.wr_addr;
               mem_wdata_s = bus.wr_data;
            end else begin
               mem_we_s    = 1'b0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            sweep_d = {(ADDR_W+1){1'b0}};
            busy_d  = 1'b1;
         end
      endcase
   end

   // Read word selection: range guard first, then optional same-address write bypass.
   always_comb begin
      rd_word_s = {DATA_W{1'b0}};
      if (!rd_ok_s) begin
         rd_word_s = {DATA_W{1'b0}};
      end else if (RDW_MODE && bus.wr_en && wr_ok_s && (bus.wr_addr == bus.rd_addr)) begin
         rd_word_s = bus.wr_data;
      end else begin
         rd_word_s = mem_q[bus.rd_addr];
      end
   end

   // Output pipeline: one or two stages; rd_data holds its value between strobes.
   always_comb begin
      s1_valid_d = 1'b0;
      s1_data_d  = s1_data_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      if (OUT_REG) begin
         s1_valid_d = rd_fire_s;
         s1_data_d  = rd_fire_s ? rd_word_s : s1_data_q;
         rd_valid_d = s1_valid_q;
         rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
      end else begin
         rd_valid_d = rd_fire_s;
         rd_data_d  = rd_fire_s ? rd_word_s : rd_data_q;
      end
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RESET_ST;
         sweep_q    <= {(ADDR_W+1){1'b0}};
         busy_q     <= INIT_CLR;
         drop_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= {DATA_W{1'b0}};
         rd_valid_q <= 1'b0;
         rd_data_q  <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage array, deliberately not reset; the sweep provides the defined contents.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = busy_q;
   assign bus.drop     = drop_q;

endmodule
